instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Decode stage placed directly upstream of the immediate sign/zero extender.
//  Accepts fetched 32-bit MIPS instructions over a valid/ready handshake and
//  registers them in a 2-entry skid buffer. Splits each into fields.
//  Generates extSel: 1 = zero-extend, 0 = sign-extend. This drives the
//  extender's extend[15:0]/extSel inputs and the register-file address ports.
// PARAMETERS
//  PC_W      32  width of the program-counter tag carried with each instruction
//  ZEXT_LUI  0   1: lui (opcode 0x0F) also asserts extSel; 0: lui sign-extends
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous, active-low reset
//  flush        in   1     synchronous kill of all buffered instructions
//  in_valid     in   1     upstream instruction present
//  in_ready     out  1     stage can accept (registered, = !skid_valid)
//  in_instr     in   32    instruction word
//  in_pc        in   PC_W  PC of in_instr
//  out_valid    out  1     decoded instruction present
//  out_ready    in   1     downstream accepts
//  out_pc       out  PC_W  PC of decoded instruction
//  out_opcode   out  6     instr[31:26]
//  out_rs/rt/rd out  5     instr[25:21] / [20:16] / [15:11]
//  out_shamt    out  5     instr[10:6]
//  out_funct    out  6     instr[5:0]
//  out_imm      out  16    instr[15:0], fed to extender 'extend'
//  out_target   out  26    instr[25:0]
//  out_extSel   out  1     1 for andi 0x0C, ori 0x0D, xori 0x0E (+lui if ZEXT_LUI)
// BEHAVIOUR
//  - Reset (rst_n=0, async): main_valid=skid_valid=0, out_valid=0, in_ready=1.
//    All data outputs are 0. State EMPTY.
//  - Transfers: in-xfer = in_valid&in_ready; out-xfer = out_valid&out_ready.
//  - Latency: an instruction accepted at edge N shows out_valid at edge N.
//    It is visible in the cycle after N.
//  - Throughput: 1 instruction/cycle while out_ready=1.
//  - Outputs are always driven from the main register. Decode happens on the
//    input side. Field outputs and extSel are registered, with no
//    comb path from in_* to out_*.
//  - FSM (main_valid, skid_valid):
//      EMPTY: in-xfer -> HALF (load main).
//      HALF : in-xfer & !out-xfer -> FULL (load skid).
//             out-xfer & !in-xfer -> EMPTY.
//             both -> HALF (main reloaded).
//      FULL : in_ready=0. out-xfer -> HALF (skid moves to main).
//             No new accept this cycle.
//  - Order is strict FIFO. No instruction is dropped or duplicated.
//  - Ready is never combinationally dependent on out_ready.
//  - Valid hold: while out_valid=1 & out_ready=0, all out_* are stable.
//  - flush=1 at an edge forces EMPTY, regardless of in_valid/out_ready.
//    A same-cycle incoming instruction is discarded.
//    in_ready=1 in the following cycle.
//  - rst_n deassertion mid-stream: the stage restarts in EMPTY.
//    Nothing is replayed.
//  - out_extSel is computed from opcode only. Funct is ignored for extSel.
// CONFIGURATION
//  ILLEGAL_OP_DETECT_EN defined:
//    Adds out_illegal (out, 1), registered alongside the fields.
//    It is 1 for opcodes outside {0x00,0x02,0x03,0x04,0x05,0x08,0x09,0x0A,
//    0x0C,0x0D,0x0E,0x0F,0x23,0x2B}.
//    For R-type, it is also 1 when funct is outside
//    {0x00,0x02,0x08,0x20,0x21,0x22,0x23,0x24,0x25,0x2A}.
//    It resets to 0. An illegal instruction still flows normally.
//  Not defined: port absent; no extra logic.
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, in_ready=1, out_imm=0, out_extSel=0.
//  2 Stream addi 0x2008FFF8, ori 0x3509FFE2, out_ready=1:
//    out_imm=0xFFF8/extSel=0, then 0xFFE2/extSel=1, one per cycle.
//  3 Backpressure: out_ready=0, send 3 instrs -> 2 accepted, in_ready=0.
//    Release: outputs emerge in order, in_ready=1 one cycle after first out-xfer.
//  4 R-type 0x012A4020 (add $8,$9,$10) -> rs=9, rt=10, rd=8, shamt=0,
//    funct=0x20, extSel=0.
//  5 FULL + flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//    Flushed instrs never appear.
//  6 ILLEGAL_OP_DETECT_EN: opcode 0x3F -> out_illegal=1.
//    0x2008FFF8 -> out_illegal=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// MIPS decode stage: valid/ready 2-entry skid buffer feeding the immediate extender.
// Optional macro ILLEGAL_OP_DETECT_EN adds a registered out_illegal flag.
module instr_decode_stage #(
    parameter int PC_W     = 32,
    parameter bit ZEXT_LUI = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm,
    output logic [25:0]     out_target,
    output logic            out_extSel
`ifdef ILLEGAL_OP_DETECT_EN
    ,
    output logic            out_illegal
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            extsel;
`ifdef ILLEGAL_OP_DETECT_EN
        logic            illegal;
`endif
    } dec_t;

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    state_t state, state_nxt;
    dec_t   dec_in, main_q, skid_q;
    logic   in_xfer, out_xfer;
    logic   ld_main_in, ld_main_skid, ld_skid;

    // Decode on the input side so the registered outputs carry no comb path.
    always_comb begin
        dec_in        = '0;
        dec_in.pc     = in_pc;
        dec_in.instr  = in_instr;
        dec_in.extsel = (in_instr[31:26] inside {6'h0C, 6'h0D, 6'h0E}) ||
                        (ZEXT_LUI && (in_instr[31:26] == 6'h0F));
`ifdef ILLEGAL_OP_DETECT_EN
        dec_in.illegal = !(in_instr[31:26] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                             6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B}) ||
                         ((in_instr[31:26] == 6'h00) &&
                          !(in_instr[5:0] inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h2A}));
`endif
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: if (in_xfer) begin
                ld_main_in = 1'b1;
                state_nxt  = HALF;
            end
            HALF: begin
                if (in_xfer && !out_xfer) begin
                    ld_skid   = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer && !in_xfer) begin
                    state_nxt = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    ld_main_in = 1'b1;
                end
            end
            FULL: if (out_xfer) begin
                ld_main_skid = 1'b1;
                state_nxt    = HALF;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over everything, including a same-cycle accept.
        if (flush) begin
            state_nxt    = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (ld_main_in)
                main_q <= dec_in;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= dec_in;
        end
    end

    assign out_pc     = main_q.pc;
    assign out_opcode = main_q.instr[31:26];
    assign out_rs     = main_q.instr[25:21];
    assign out_rt     = main_q.instr[20:16];
    assign out_rd     = main_q.instr[15:11];
    assign out_shamt  = main_q.instr[10:6];
    assign out_funct  = main_q.instr[5:0];
    assign out_imm    = main_q.instr[15:0];
    assign out_target = main_q.instr[25:0];
    assign out_extSel = main_q.extsel;
`ifdef ILLEGAL_OP_DETECT_EN
    assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: occupancy model + expected-field queue,
// with a negedge monitor comparing every presented output against the queue head.
module tb_instr_decode_stage;
    localparam int PC_W     = 32;
    localparam bit ZEXT_LUI = 1'b0;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [5:0]      out_opcode, out_funct;
    logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
    logic [15:0]     out_imm;
    logic [25:0]     out_target;
    logic            out_extSel;
`ifdef ILLEGAL_OP_DETECT_EN
    logic            out_illegal;
`endif

    instr_decode_stage #(.PC_W(PC_W), .ZEXT_LUI(ZEXT_LUI)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
        .out_target(out_target), .out_extSel(out_extSel)
`ifdef ILLEGAL_OP_DETECT_EN
        , .out_illegal(out_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        extsel;
        logic        illegal;
    } exp_t;

    exp_t        sbq[$];
    int          occ = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit in_list(input logic [5:0] v, input bit is_funct);
        logic [5:0] ops[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [5:0] fns[10] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h24, 6'h25, 6'h2A};
        bit hit = 1'b0;
        if (is_funct) begin
            foreach (fns[i]) if (fns[i] == v) hit = 1'b1;
        end else begin
            foreach (ops[i]) if (ops[i] == v) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reference: field extraction and extend/illegal rules straight from the ISA tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.pc      = pc;
        e.op      = ins[31:26];
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.rd      = ins[15:11];
        e.shamt   = ins[10:6];
        e.funct   = ins[5:0];
        e.imm     = ins[15:0];
        e.target  = ins[25:0];
        e.extsel  = (e.op == 6'h0C) || (e.op == 6'h0D) || (e.op == 6'h0E) ||
                    (ZEXT_LUI && e.op == 6'h0F);
`ifdef ILLEGAL_OP_DETECT_EN
        e.illegal = !in_list(e.op, 1'b0) || (e.op == 6'h00 && !in_list(e.funct, 1'b1));
`else
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.pc = out_pc; a.op = out_opcode; a.rs = out_rs; a.rt = out_rt; a.rd = out_rd;
        a.shamt = out_shamt; a.funct = out_funct; a.imm = out_imm; a.target = out_target;
        a.extsel = out_extSel;
`ifdef ILLEGAL_OP_DETECT_EN
        a.illegal = out_illegal;
`else
        a.illegal = 1'b0;
`endif
        return a;
    endfunction

    // One clock of stimulus; afterwards the occupancy model predicts ready/valid.
    task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
        int   pre;
        bit   acc;
        exp_t e;
        in_valid = iv; in_instr = ins; in_pc = pc_ctr; out_ready = ordy; flush = fl;
        e = model(ins, pc_ctr);
        @(posedge clk); #1;
        pre = occ;
        if (fl) begin
            occ = 0;
            sbq.delete();
        end else begin
            acc = iv && (pre < 2);
            occ = pre - ((ordy && pre > 0) ? 1 : 0) + (acc ? 1 : 0);
            if (acc) sbq.push_back(e);
        end
        pc_ctr += 4;
        chk("in_ready", in_ready, occ < 2);
        chk("out_valid", out_valid, occ > 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_extSel", out_extSel, 0);
        chk("rst_out_pc", out_pc, 0);
        occ = 0;
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented word must match the queue head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL data: out_valid=1 pc=%h, expected no instruction", out_pc);
            end else begin
                chk("data", actual(), sbq[0]);
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 13)];
        return w;
    endfunction

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #1;
        do_reset();

        // addi then ori streamed back to back
        step(1, 32'h2008FFF8, 1, 0);
        step(1, 32'h3509FFE2, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // backpressure: third word refused until drain starts
        step(1, 32'h24010001, 0, 0);
        step(1, 32'h24020002, 0, 0);
        step(1, 32'h24030003, 0, 0);
        step(1, 32'h24030003, 0, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // R-type add $8,$9,$10 and lui
        step(1, 32'h012A4020, 1, 0);
        step(1, 32'h3C011234, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // fill, then flush with a word offered in the same cycle
        step(1, 32'h2108AAAA, 0, 0);
        step(1, 32'h2108BBBB, 0, 0);
        step(1, 32'h2108CCCC, 0, 1);
        step(0, 32'h0, 1, 0);
        step(1, 32'h31EF00FF, 1, 0);
        step(0, 32'h0, 1, 0);

        // illegal opcode, then a legal one
        step(1, 32'hFC000000, 1, 0);
        step(1, 32'h2008FFF8, 1, 0);
        step(1, 32'h0000003F, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // mid-stream reset while holding data
        step(1, 32'h35AB1234, 0, 0);
        step(1, 32'h35AB5678, 0, 0);
        do_reset();

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
